// File: rtl/sc_speed_pkg.sv
// Shared types and constants for the speed-driven move tick generator.
// Holds the FSM encoding, default parameter values and the clamp-level helper.
package sc_speed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } sc_state_e;

    localparam int unsigned DEF_SPEED_DATAWIDTH  = 24;
    localparam int unsigned DEF_PERIOD_DATAWIDTH = 26;
    localparam int unsigned DEF_BASE_PERIOD      = 25_000_000;
    localparam int unsigned DEF_STEP_PERIOD      = 2_500_000;
    localparam int unsigned DEF_MIN_PERIOD       = 2_500_000;

    // First speed level whose linear period would reach or pass the floor.
    function automatic int unsigned sc_max_level(input int unsigned base_period,
                                                 input int unsigned min_period,
                                                 input int unsigned step_period);
        return (base_period - min_period) / step_period;
    endfunction

endpackage

// File: rtl/sc_speed_tick_gen_if.sv
// Signal bundle between the speed counter side and the tick generator.
// Handshake: none -- level/run/clear are sampled every clock; outputs are registered levels/pulses.
interface sc_speed_tick_gen_if
    import sc_speed_pkg::*;
#(
    parameter int unsigned SPEED_DATAWIDTH  = DEF_SPEED_DATAWIDTH,
    parameter int unsigned PERIOD_DATAWIDTH = DEF_PERIOD_DATAWIDTH
);
    logic [SPEED_DATAWIDTH-1:0]  SC_speed_level_InBUS;
    logic                        SC_run_InLow;
    logic                        SC_clear_InLow;
    logic                        SC_tick_OutLow;
    logic [PERIOD_DATAWIDTH-1:0] SC_period_OutBUS;
    logic [7:0]                  SC_tickcount_OutBUS;
    sc_state_e                   SC_state_OutDBG;

    modport master (
        output SC_speed_level_InBUS,
        output SC_run_InLow,
        output SC_clear_InLow,
        input  SC_tick_OutLow,
        input  SC_period_OutBUS,
        input  SC_tickcount_OutBUS,
        input  SC_state_OutDBG
    );

    modport slave (
        input  SC_speed_level_InBUS,
        input  SC_run_InLow,
        input  SC_clear_InLow,
        output SC_tick_OutLow,
        output SC_period_OutBUS,
        output SC_tickcount_OutBUS,
        output SC_state_OutDBG
    );
endinterface

// File: rtl/sc_speed_period_calc.sv
// Combinational speed level to tick period mapping with a floor clamp.
// The clamp compare runs at full level width so the multiply never sees a large level.
module sc_speed_period_calc
    import sc_speed_pkg::*;
#(
    parameter int unsigned SPEED_DATAWIDTH  = DEF_SPEED_DATAWIDTH,
    parameter int unsigned PERIOD_DATAWIDTH = DEF_PERIOD_DATAWIDTH,
    parameter int unsigned BASE_PERIOD      = DEF_BASE_PERIOD,
    parameter int unsigned STEP_PERIOD      = DEF_STEP_PERIOD,
    parameter int unsigned MIN_PERIOD       = DEF_MIN_PERIOD
) (
    input  logic [SPEED_DATAWIDTH-1:0]  level_i,
    output logic [PERIOD_DATAWIDTH-1:0] period_o
);
    localparam int unsigned MAX_LEVEL = sc_max_level(BASE_PERIOD, MIN_PERIOD, STEP_PERIOD);
    localparam logic [SPEED_DATAWIDTH-1:0]  MAX_LEVEL_W = SPEED_DATAWIDTH'(MAX_LEVEL);
    localparam logic [PERIOD_DATAWIDTH-1:0] BASE_W      = PERIOD_DATAWIDTH'(BASE_PERIOD);
    localparam logic [PERIOD_DATAWIDTH-1:0] STEP_W      = PERIOD_DATAWIDTH'(STEP_PERIOD);
    localparam logic [PERIOD_DATAWIDTH-1:0] MIN_W       = PERIOD_DATAWIDTH'(MIN_PERIOD);

    logic [PERIOD_DATAWIDTH-1:0] level_p;

    // Below MAX_LEVEL the level is small enough that narrowing it is lossless.
    assign level_p = PERIOD_DATAWIDTH'(level_i);

    always_comb begin
        period_o = MIN_W;
        if (level_i < MAX_LEVEL_W) begin
            period_o = BASE_W - (level_p * STEP_W);
        end
    end
endmodule

// File: rtl/sc_speed_tick_gen.sv
// Move tick generator: counts down the speed-derived period and emits a one-cycle low tick.
// The period is only re-evaluated at period boundaries, so level changes never glitch a period.
module sc_speed_tick_gen
    import sc_speed_pkg::*;
#(
    parameter int unsigned SPEED_DATAWIDTH  = DEF_SPEED_DATAWIDTH,
    parameter int unsigned PERIOD_DATAWIDTH = DEF_PERIOD_DATAWIDTH,
    parameter int unsigned BASE_PERIOD      = DEF_BASE_PERIOD,
    parameter int unsigned STEP_PERIOD      = DEF_STEP_PERIOD,
    parameter int unsigned MIN_PERIOD       = DEF_MIN_PERIOD
) (
    input  logic                SC_upSPEEDCOUNTER_CLOCK_50,
    input  logic                SC_upSPEEDCOUNTER_RESET_InHigh,
    sc_speed_tick_gen_if.slave  io
);
    sc_state_e                   state_q, state_d;
    logic [PERIOD_DATAWIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_DATAWIDTH-1:0] period_q, period_d;
    logic                        tick_q, tick_d;
    logic [7:0]                  tickcount_q, tickcount_d;
    logic [PERIOD_DATAWIDTH-1:0] calc_period;

    sc_speed_period_calc #(
        .SPEED_DATAWIDTH  (SPEED_DATAWIDTH),
        .PERIOD_DATAWIDTH (PERIOD_DATAWIDTH),
        .BASE_PERIOD      (BASE_PERIOD),
        .STEP_PERIOD      (STEP_PERIOD),
        .MIN_PERIOD       (MIN_PERIOD)
    ) u_period_calc (
        .level_i  (io.SC_speed_level_InBUS),
        .period_o (calc_period)
    );

    always_ff @(posedge SC_upSPEEDCOUNTER_CLOCK_50 or posedge SC_upSPEEDCOUNTER_RESET_InHigh) begin
        if (SC_upSPEEDCOUNTER_RESET_InHigh) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= PERIOD_DATAWIDTH'(BASE_PERIOD);
            tick_q      <= 1'b1;
            tickcount_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            tick_q      <= tick_d;
            tickcount_q <= tickcount_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        tick_d      = 1'b1;
        tickcount_d = tickcount_q;

        if (!io.SC_clear_InLow) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            tickcount_d = '0;
            period_d    = calc_period;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!io.SC_run_InLow) begin
                        state_d  = ST_RUN;
                        period_d = calc_period;
                        cnt_d    = calc_period - PERIOD_DATAWIDTH'(1);
                    end
                end
                // Resuming from PAUSE counts on the same edge, so an N-cycle pause costs exactly N.
                ST_RUN, ST_PAUSE: begin
                    if (io.SC_run_InLow) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - PERIOD_DATAWIDTH'(1);
                        end else begin
                            tick_d      = 1'b0;
                            tickcount_d = tickcount_q + 8'd1;
                            period_d    = calc_period;
                            cnt_d       = calc_period - PERIOD_DATAWIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign io.SC_tick_OutLow      = tick_q;
    assign io.SC_period_OutBUS    = period_q;
    assign io.SC_tickcount_OutBUS = tickcount_q;
    assign io.SC_state_OutDBG     = state_q;
endmodule

// File: tb/tb_sc_speed_tick_gen.sv
// Directed bench for sc_speed_tick_gen with BASE=10, STEP=2, MIN=4 (clamp from level 3).
// Edge 0 of each scenario is the edge that moves the DUT from IDLE into RUN.
module tb_sc_speed_tick_gen;
    import sc_speed_pkg::*;

    localparam int unsigned SW = 24;
    localparam int unsigned PW = 26;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sc_speed_tick_gen_if #(.SPEED_DATAWIDTH(SW), .PERIOD_DATAWIDTH(PW)) bus ();

    sc_speed_tick_gen #(
        .SPEED_DATAWIDTH  (SW),
        .PERIOD_DATAWIDTH (PW),
        .BASE_PERIOD      (10),
        .STEP_PERIOD      (2),
        .MIN_PERIOD       (4)
    ) dut (
        .SC_upSPEEDCOUNTER_CLOCK_50     (clk),
        .SC_upSPEEDCOUNTER_RESET_InHigh (rst),
        .io                             (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Clear, then let the next edge (edge 0) start RUN with the given level.
    task automatic restart(input logic [SW-1:0] lvl);
        bus.SC_speed_level_InBUS = lvl;
        bus.SC_run_InLow         = 1'b0;
        bus.SC_clear_InLow       = 1'b0;
        tick_clk();
        bus.SC_clear_InLow       = 1'b1;
        tick_clk();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SC_speed_level_InBUS = '0;
        bus.SC_run_InLow         = 1'b1;
        bus.SC_clear_InLow       = 1'b1;
        tick_clk();
        tick_clk();
        n_vec++;
        if (bus.SC_state_OutDBG !== ST_IDLE) begin
            n_err++; $display("FAIL reset_state got %0d expected %0d", bus.SC_state_OutDBG, ST_IDLE);
        end
        n_vec++;
        if (bus.SC_tick_OutLow !== 1'b1) begin
            n_err++; $display("FAIL reset_tick got %b expected 1", bus.SC_tick_OutLow);
        end
        n_vec++;
        if (bus.SC_period_OutBUS !== PW'(10)) begin
            n_err++; $display("FAIL reset_period got %0d expected 10", bus.SC_period_OutBUS);
        end
        n_vec++;
        if (bus.SC_tickcount_OutBUS !== 8'd0) begin
            n_err++; $display("FAIL reset_tickcount got %0d expected 0", bus.SC_tickcount_OutBUS);
        end
        rst = 1'b0;
        tick_clk();
        n_vec++;
        if (bus.SC_state_OutDBG !== ST_IDLE) begin
            n_err++; $display("FAIL idle_hold_state got %0d expected %0d", bus.SC_state_OutDBG, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        logic exp_tick;
        restart('0);
        n_vec++;
        if (bus.SC_state_OutDBG !== ST_RUN) begin
            n_err++; $display("FAIL basic_run_state got %0d expected %0d", bus.SC_state_OutDBG, ST_RUN);
        end
        for (int k = 1; k <= 30; k++) begin
            tick_clk();
            exp_tick = (k % 10 == 0) ? 1'b0 : 1'b1;
            n_vec++;
            if (bus.SC_tick_OutLow !== exp_tick) begin
                n_err++; $display("FAIL basic_tick cycle %0d got %b expected %b", k, bus.SC_tick_OutLow, exp_tick);
            end
            if (k % 10 == 0) begin
                n_vec++;
                if (bus.SC_tickcount_OutBUS !== 8'(k / 10)) begin
                    n_err++; $display("FAIL basic_tickcount cycle %0d got %0d expected %0d", k, bus.SC_tickcount_OutBUS, k / 10);
                end
                n_vec++;
                if (bus.SC_period_OutBUS !== PW'(10)) begin
                    n_err++; $display("FAIL basic_period cycle %0d got %0d expected 10", k, bus.SC_period_OutBUS);
                end
            end
        end
    endtask

    task automatic test_level_change();
        logic exp_tick;
        logic [PW-1:0] exp_period;
        restart('0);
        for (int k = 1; k <= 16; k++) begin
            tick_clk();
            if (k == 4) bus.SC_speed_level_InBUS = 24'd2;
            exp_tick   = (k == 10 || k == 16) ? 1'b0 : 1'b1;
            exp_period = (k >= 10) ? PW'(6) : PW'(10);
            n_vec++;
            if (bus.SC_tick_OutLow !== exp_tick) begin
                n_err++; $display("FAIL lvlchg_tick cycle %0d got %b expected %b", k, bus.SC_tick_OutLow, exp_tick);
            end
            n_vec++;
            if (bus.SC_period_OutBUS !== exp_period) begin
                n_err++; $display("FAIL lvlchg_period cycle %0d got %0d expected %0d", k, bus.SC_period_OutBUS, exp_period);
            end
        end
    endtask

    task automatic test_clamp();
        logic [SW-1:0] lvls [4];
        int            pers [4];
        logic          exp_tick;
        lvls = '{24'd1, 24'd3, 24'd1000, 24'hFFFFFF};
        pers = '{8, 4, 4, 4};
        for (int t = 0; t < 4; t++) begin
            restart(lvls[t]);
            n_vec++;
            if (bus.SC_period_OutBUS !== PW'(pers[t])) begin
                n_err++; $display("FAIL clamp_period level %0d got %0d expected %0d", lvls[t], bus.SC_period_OutBUS, pers[t]);
            end
            for (int k = 1; k <= 3 * pers[t]; k++) begin
                tick_clk();
                exp_tick = (k % pers[t] == 0) ? 1'b0 : 1'b1;
                n_vec++;
                if (bus.SC_tick_OutLow !== exp_tick) begin
                    n_err++; $display("FAIL clamp_tick level %0d cycle %0d got %b expected %b", lvls[t], k, bus.SC_tick_OutLow, exp_tick);
                end
            end
        end
    endtask

    task automatic test_pause();
        logic      exp_tick;
        sc_state_e exp_state;
        restart('0);
        for (int k = 1; k <= 25; k++) begin
            tick_clk();
            exp_tick  = (k == 15 || k == 25) ? 1'b0 : 1'b1;
            exp_state = (k >= 4 && k <= 8) ? ST_PAUSE : ST_RUN;
            n_vec++;
            if (bus.SC_tick_OutLow !== exp_tick) begin
                n_err++; $display("FAIL pause_tick cycle %0d got %b expected %b", k, bus.SC_tick_OutLow, exp_tick);
            end
            n_vec++;
            if (bus.SC_state_OutDBG !== exp_state) begin
                n_err++; $display("FAIL pause_state cycle %0d got %0d expected %0d", k, bus.SC_state_OutDBG, exp_state);
            end
            bus.SC_run_InLow = (k >= 3 && k < 8) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic test_clear_and_reset();
        restart('0);
        for (int k = 1; k <= 19; k++) tick_clk();
        n_vec++;
        if (bus.SC_tickcount_OutBUS !== 8'd1) begin
            n_err++; $display("FAIL clear_pre_tickcount got %0d expected 1", bus.SC_tickcount_OutBUS);
        end
        bus.SC_clear_InLow = 1'b0;
        tick_clk();
        bus.SC_clear_InLow = 1'b1;
        bus.SC_run_InLow   = 1'b1;
        n_vec++;
        if (bus.SC_tick_OutLow !== 1'b1) begin
            n_err++; $display("FAIL clear_tick_suppressed got %b expected 1", bus.SC_tick_OutLow);
        end
        n_vec++;
        if (bus.SC_state_OutDBG !== ST_IDLE) begin
            n_err++; $display("FAIL clear_state got %0d expected %0d", bus.SC_state_OutDBG, ST_IDLE);
        end
        n_vec++;
        if (bus.SC_tickcount_OutBUS !== 8'd0) begin
            n_err++; $display("FAIL clear_tickcount got %0d expected 0", bus.SC_tickcount_OutBUS);
        end
        tick_clk();
        n_vec++;
        if (bus.SC_tick_OutLow !== 1'b1) begin
            n_err++; $display("FAIL clear_idle_tick got %b expected 1", bus.SC_tick_OutLow);
        end

        restart(24'd2);
        for (int k = 1; k <= 6; k++) tick_clk();
        n_vec++;
        if (bus.SC_tick_OutLow !== 1'b0) begin
            n_err++; $display("FAIL areset_pre_tick got %b expected 0", bus.SC_tick_OutLow);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.SC_tick_OutLow !== 1'b1) begin
            n_err++; $display("FAIL areset_tick got %b expected 1", bus.SC_tick_OutLow);
        end
        n_vec++;
        if (bus.SC_period_OutBUS !== PW'(10)) begin
            n_err++; $display("FAIL areset_period got %0d expected 10", bus.SC_period_OutBUS);
        end
        n_vec++;
        if (bus.SC_tickcount_OutBUS !== 8'd0) begin
            n_err++; $display("FAIL areset_tickcount got %0d expected 0", bus.SC_tickcount_OutBUS);
        end
        n_vec++;
        if (bus.SC_state_OutDBG !== ST_IDLE) begin
            n_err++; $display("FAIL areset_state got %0d expected %0d", bus.SC_state_OutDBG, ST_IDLE);
        end
        tick_clk();
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        logic exp_tick;
        restart(24'd3);
        for (int k = 1; k <= 1024; k++) begin
            tick_clk();
            exp_tick = (k % 4 == 0) ? 1'b0 : 1'b1;
            n_vec++;
            if (bus.SC_tick_OutLow !== exp_tick) begin
                n_err++; $display("FAIL wrap_tick cycle %0d got %b expected %b", k, bus.SC_tick_OutLow, exp_tick);
            end
            if (k == 1020 || k == 1024) begin
                n_vec++;
                if (bus.SC_tickcount_OutBUS !== ((k == 1020) ? 8'd255 : 8'd0)) begin
                    n_err++; $display("FAIL wrap_tickcount cycle %0d got %0d expected %0d", k, bus.SC_tickcount_OutBUS, (k == 1020) ? 255 : 0);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_level_change();
        test_clamp();
        test_pause();
        test_clear_and_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sc_speed_tick_gen.md
# sc_speed_tick_gen

Converts the speed level produced by the upstream up speed counter into a periodic one-cycle move tick that drives lane/obstacle motion. The tick period shrinks linearly with speed level down to a floor. The new period is applied only at period boundaries, so speed changes never produce a short or glitched period. It sits directly downstream of the speed counter and upstream of the lane shift logic.

## Interface
- SPEED_DATAWIDTH, 24, width of speed level input; matches the speed counter bus.
- PERIOD_DATAWIDTH, 26, width of period/countdown registers; must hold BASE_PERIOD.
- BASE_PERIOD, 25_000_000, period in clocks at level 0 (0.5 s at 50 MHz).
- STEP_PERIOD, 2_500_000, period reduction per level.
- MIN_PERIOD, 2_500_000, period floor; must be ≥ 2.

Ports:
- SC_upSPEEDCOUNTER_CLOCK_50  in  1  system clock.
- SC_upSPEEDCOUNTER_RESET_InHigh  in  1  reset, asynchronous, active-high.
- SC_speed_level_InBUS  in  SPEED_DATAWIDTH  current speed level from the speed counter.
- SC_run_InLow  in  1  0 = run/resume, 1 = pause.
- SC_clear_InLow  in  1  synchronous restart, active-low.
- SC_tick_OutLow  out  1  registered one-cycle low pulse per period.
- SC_period_OutBUS  out  PERIOD_DATAWIDTH  period currently in force.
- SC_tickcount_OutBUS  out  8  ticks since clear, wraps.

## Operation
- Period calc, combinational: MAX_LEVEL = (BASE_PERIOD-MIN_PERIOD)/STEP_PERIOD.
  - level ≥ MAX_LEVEL → MIN_PERIOD.
  - Otherwise → BASE_PERIOD - level*STEP_PERIOD.
  - Compare at full SPEED_DATAWIDTH before multiplying, so there is no overflow for any level.
- State machine: IDLE (00), RUN (01), PAUSE (10).
- IDLE:
  - Tick held high, count held.
  - run low → RUN; load period_reg = calc(level) and cnt = calc(level)-1.
- RUN:
  - run high → PAUSE; cnt frozen.
  - Otherwise, if cnt != 0 → cnt-1.
  - Otherwise (cnt == 0):
    - Tick pulses low next cycle.
    - tickcount+1, wrapping 255 → 0.
    - period_reg = calc(level) and cnt = calc(level)-1 (reload with the current level).
- PAUSE:
  - No ticks, cnt held.
  - run low → RUN; resume from the held cnt, no reload.
- clear low, in any state:
  - Highest priority after reset.
  - state ← IDLE, cnt ← 0, tickcount ← 0, tick high, period_reg ← calc(level).
  - A clear coincident with cnt == 0 suppresses that tick.
- A level change mid-period has no effect until the next reload.

## Timing
- Reset values: state IDLE, cnt 0, SC_period_OutBUS = BASE_PERIOD, SC_tick_OutLow = 1, SC_tickcount_OutBUS = 0.
- Reset is asynchronous and takes effect immediately, mid-period included.
- All outputs are registered; there is no combinational path from input to output.
- RUN entered at edge E → first tick low during the cycle after edge E+P, then every P cycles.
- Tick width is exactly one clock. Periods are never shorter than MIN_PERIOD.
- Pausing for N cycles delays all subsequent ticks by exactly N.
- SC_period_OutBUS updates on the same edge as the reload.

## Structure
- Package sc_speed_pkg holds:
  - state enum and encodings;
  - default parameter constants;
  - the MAX_LEVEL constant function.
- Sub-module sc_speed_period_calc: combinational level → period with clamp, parameterised identically. The top instantiates it once.
- Top contains the FSM, countdown, tick register and tick counter. Target is about 150–250 lines of RTL.

## Test plan
Bench parameters: BASE_PERIOD=10, STEP_PERIOD=2, MIN_PERIOD=4, giving MAX_LEVEL=3.
- **Basic ticking:** reset, level 0, run low at edge 0 → tick low at cycles 10, 20, 30. tickcount reads 1, 2, 3. period = 10.
- **Level change mid-period:** level 0 → 2 at cycle 4 → tick at 10, next tick at 16. period reads 6 from edge 10.
- **Clamp:** level 3 → period 4. Level 1000 and level 2^24-1 → period 4, with ticks every 4 cycles.
- **Pause:** run high for 5 cycles at mid-count → next tick 5 cycles late. No tick while paused, and no reload on resume.
- **Clear and reset:** clear low coincident with cnt == 0 → no tick, IDLE, tickcount 0. Async reset mid-period → outputs reach their reset values before the next edge.
- **Wrap:** 256 ticks → tickcount 255 then 0. Tick width is exactly 1 cycle on every pulse.
